leaf_candidate_fetch: RTL and testbench
=======================================

LEAF_CANDIDATE_FETCH -- requirements
Module: leaf_candidate_fetch

Interface
REQ-001 SHALL have parameter PATCH_WIDTH, default 55: query/candidate patch width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8: leaf index width from the internal node tree.
REQ-003 SHALL have parameter LEAF_SIZE_LOG2, default 3: LEAF_SIZE = 2^LEAF_SIZE_LOG2 candidate patches per leaf.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port wrst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: query patch and leaf index valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a query.
REQ-008 SHALL have port in_patch, input, PATCH_WIDTH: query patch.
REQ-009 SHALL have port in_leaf_index, input, ADDRESS_WIDTH: leaf chosen by the tree.
REQ-010 SHALL have port mem_ren, output, 1: leaf memory read enable.
REQ-011 SHALL have port mem_addr, output, ADDRESS_WIDTH+LEAF_SIZE_LOG2: {leaf_index, slot}.
REQ-012 SHALL have port mem_rdata, input, PATCH_WIDTH: candidate patch, valid one cycle after mem_ren.
REQ-013 SHALL have port out_valid, input/output: output, 1: candidate pair valid.
REQ-014 SHALL have port out_ready, input, 1: downstream distance stage accepts.
REQ-015 SHALL have ports out_query (PATCH_WIDTH), out_cand (PATCH_WIDTH), out_leaf_index (ADDRESS_WIDTH), out_slot (LEAF_SIZE_LOG2), out_last (1), all outputs.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DATA, OUT.
REQ-018 in_ready SHALL equal (state==IDLE); handshake = in_valid && in_ready at a rising clk edge.
REQ-019 On handshake: capture in_patch and in_leaf_index into query registers, clear slot to 0, go to ISSUE.
REQ-020 ISSUE: mem_ren=1, mem_addr={leaf reg, slot}; next state DATA; mem_ren SHALL be 0 in all other states.
REQ-021 DATA: capture mem_rdata into out_cand, slot into out_slot, out_last=(slot==LEAF_SIZE-1); next state OUT.
REQ-022 OUT: out_valid=1; hold all out_* stable until out_valid && out_ready.
REQ-023 On OUT handshake: if out_last, go to IDLE; else increment slot, go to ISSUE.
REQ-024 Latency: first out_valid SHALL rise in the 3rd cycle after the accept edge; with out_ready held high each candidate takes 3 cycles, a full leaf 3*LEAF_SIZE cycles.
REQ-025 out_query and out_leaf_index SHALL equal the captured query for all LEAF_SIZE outputs of one query.
REQ-026 in_valid while busy SHALL be ignored; no query lost or overwritten.
REQ-027 Slot counter SHALL be LEAF_SIZE_LOG2 bits; no wrap beyond LEAF_SIZE-1 is emitted; leaf index 2^ADDRESS_WIDTH-1 SHALL address the top of memory without overflow.
REQ-028 out_ready changes while out_valid low SHALL have no effect.

Reset
REQ-029 While wrst_n low at a clk edge: state IDLE, slot 0, out_valid 0, mem_ren 0, busy 0, out_last 0, all data registers 0.
REQ-030 in_ready SHALL be 0 while wrst_n is low, 1 in the first cycle after release.
REQ-031 Reset mid-operation SHALL discard the current query and emit no further candidates.

Verification
REQ-032 Reset release, in_valid=0 -> in_ready=1, out_valid=0, mem_ren=0, busy=0 steady.
REQ-033 Query leaf 5, out_ready=1 -> mem_addr 40..47 in order, 8 outputs, out_slot 0..7, out_last only on slot 7, out_cand = memory model contents, 24 cycles accept-to-IDLE.
REQ-034 Leaf 255 -> mem_addr 2040..2047, no overflow, out_leaf_index=255 on all outputs.
REQ-035 out_ready random 50% -> out_* stable while stalled, all 8 candidates delivered once, in order.
REQ-036 in_valid held high with changing in_patch during a leaf -> second query accepted only after slot 7 handshake; first query's out_query unchanged.
REQ-037 wrst_n low during slot 3 OUT -> next cycle out_valid=0, busy=0; after release, new query leaf 2 starts at mem_addr 16.

Source files
------------

// File: rtl/leaf_candidate_fetch.sv
// Leaf candidate fetch: accepts a query patch and a leaf index, reads every
// candidate patch of that leaf from leaf memory, and streams one
// (query, candidate) pair per slot to the downstream distance stage.
module leaf_candidate_fetch #(
    parameter int unsigned PATCH_WIDTH    = 55,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned LEAF_SIZE_LOG2 = 3
) (
    input  logic                                    clk,
    input  logic                                    wrst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [PATCH_WIDTH-1:0]                  in_patch,
    input  logic [ADDRESS_WIDTH-1:0]                in_leaf_index,
    output logic                                    mem_ren,
    output logic [ADDRESS_WIDTH+LEAF_SIZE_LOG2-1:0] mem_addr,
    input  logic [PATCH_WIDTH-1:0]                  mem_rdata,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PATCH_WIDTH-1:0]                  out_query,
    output logic [PATCH_WIDTH-1:0]                  out_cand,
    output logic [ADDRESS_WIDTH-1:0]                out_leaf_index,
    output logic [LEAF_SIZE_LOG2-1:0]               out_slot,
    output logic                                    out_last,
    output logic                                    busy
);

    localparam int unsigned LEAF_SIZE = 1 << LEAF_SIZE_LOG2;
    localparam int unsigned MEM_AW    = ADDRESS_WIDTH + LEAF_SIZE_LOG2;
    localparam logic [LEAF_SIZE_LOG2-1:0] LAST_SLOT = LEAF_SIZE_LOG2'(LEAF_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                      state, state_d;
    logic [LEAF_SIZE_LOG2-1:0]   slot, slot_d;
    logic [PATCH_WIDTH-1:0]      query_d, cand_d;
    logic [ADDRESS_WIDTH-1:0]    leaf_d;
    logic [LEAF_SIZE_LOG2-1:0]   out_slot_d;
    logic                        out_last_d;
    logic [MEM_AW-1:0]           mem_addr_d;
    logic                        in_ready_d, mem_ren_d, out_valid_d, busy_d;

    // Next-state and next-register values; status outputs are decoded from
    // the next state so they come straight out of flops. The query and leaf
    // registers double as out_query / out_leaf_index.
    always_comb begin
        state_d    = state;
        slot_d     = slot;
        query_d    = out_query;
        leaf_d     = out_leaf_index;
        cand_d     = out_cand;
        out_slot_d = out_slot;
        out_last_d = out_last;
        mem_addr_d = mem_addr;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    query_d = in_patch;
                    leaf_d  = in_leaf_index;
                    slot_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = DATA;
            end
            DATA: begin
                cand_d     = mem_rdata;
                out_slot_d = slot;
                out_last_d = (slot == LAST_SLOT);
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = IDLE;
                    end else begin
                        slot_d  = slot + LEAF_SIZE_LOG2'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ISSUE) begin
            mem_addr_d = {leaf_d, slot_d};
        end

        in_ready_d  = (state_d == IDLE);
        mem_ren_d   = (state_d == ISSUE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            state          <= IDLE;
            slot           <= '0;
            out_query      <= '0;
            out_leaf_index <= '0;
            out_cand       <= '0;
            out_slot       <= '0;
            out_last       <= 1'b0;
            mem_addr       <= '0;
            in_ready       <= 1'b0;
            mem_ren        <= 1'b0;
            out_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            slot           <= slot_d;
            out_query      <= query_d;
            out_leaf_index <= leaf_d;
            out_cand       <= cand_d;
            out_slot       <= out_slot_d;
            out_last       <= out_last_d;
            mem_addr       <= mem_addr_d;
            in_ready       <= in_ready_d;
            mem_ren        <= mem_ren_d;
            out_valid      <= out_valid_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_leaf_candidate_fetch.sv
// Directed bench for leaf_candidate_fetch with a synchronous leaf memory model.
module tb_leaf_candidate_fetch;

    localparam int unsigned PW = 55;
    localparam int unsigned AW = 8;
    localparam int unsigned SL = 3;

    logic          clk = 1'b0;
    logic          wrst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_patch;
    logic [AW-1:0] in_leaf_index;
    logic          mem_ren;
    logic [AW+SL-1:0] mem_addr;
    logic [PW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_query;
    logic [PW-1:0] out_cand;
    logic [AW-1:0] out_leaf_index;
    logic [SL-1:0] out_slot;
    logic          out_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    leaf_candidate_fetch #(.PATCH_WIDTH(PW), .ADDRESS_WIDTH(AW), .LEAF_SIZE_LOG2(SL)) dut (
        .clk(clk), .wrst_n(wrst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_patch(in_patch), .in_leaf_index(in_leaf_index),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_query(out_query), .out_cand(out_cand),
        .out_leaf_index(out_leaf_index), .out_slot(out_slot),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Leaf memory contents as a function of address.
    function automatic logic [PW-1:0] mem_val(input logic [AW+SL-1:0] a);
        return {33'h1_2345_6789 ^ {22'd0, a}, a, ~a};
    endfunction

    // Synchronous-read memory: data valid one cycle after mem_ren.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_val(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one query while IDLE; returns one cycle after the accept edge.
    task automatic accept(input logic [AW-1:0] leaf, input logic [PW-1:0] patch);
        in_valid      = 1'b1;
        in_leaf_index = leaf;
        in_patch      = patch;
        check("accept_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Follow one query from the cycle after its accept edge to the return
    // to IDLE. rnd randomises out_ready; hold keeps in_valid high with a
    // changing in_patch during the whole leaf.
    task automatic serve(input logic [AW-1:0] leaf, input logic [PW-1:0] patch,
                         input bit rnd, input bit hold);
        int c = 1;
        int got = 0;
        int naddr = 0;
        int first_valid = -1;
        bit stalled = 1'b0;
        logic [PW-1:0] s_cand = '0;
        logic [SL-1:0] s_slot = '0;
        logic          s_last = 1'b0;
        logic [AW+SL-1:0] ea;
        while (got < 8 && c < 400) begin
            if (hold) begin
                in_valid = 1'b1;
                in_patch = PW'({$urandom(), $urandom()});
            end
            check("busy_in_ready_low", 64'({busy, in_ready}), 64'b10);
            if (mem_ren) begin
                ea = {leaf, SL'(naddr)};
                check("mem_addr", 64'(mem_addr), 64'(ea));
                naddr++;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (stalled) begin
                    check("stall_cand", 64'(out_cand), 64'(s_cand));
                    check("stall_slot_last", 64'({out_slot, out_last}), 64'({s_slot, s_last}));
                end else begin
                    ea = {leaf, SL'(got)};
                    check("out_cand", 64'(out_cand), 64'(mem_val(ea)));
                    check("out_slot", 64'(out_slot), 64'(got));
                    check("out_last", 64'(out_last), 64'(got == 7));
                end
                check("out_query", 64'(out_query), 64'(patch));
                check("out_leaf_index", 64'(out_leaf_index), 64'(leaf));
                s_cand = out_cand;
                s_slot = out_slot;
                s_last = out_last;
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            step();
            c++;
        end
        check("cands_delivered", 64'(got), 64'd8);
        check("mem_reads", 64'(naddr), 64'd8);
        if (!rnd) begin
            check("first_valid_cycle", 64'(first_valid), 64'd3);
            check("accept_to_idle", 64'(c - 1), 64'd24);
        end
        check("idle_after_leaf", 64'({in_ready, busy, out_valid, mem_ren}), 64'b1000);
    endtask

    initial begin
        logic [PW-1:0] p2;
        wrst_n        = 1'b0;
        in_valid      = 1'b0;
        in_patch      = '0;
        in_leaf_index = '0;
        out_ready     = 1'b0;
        repeat (3) step();

        // Reset values.
        check("rst_flags", 64'({in_ready, out_valid, mem_ren, busy, out_last}), 64'd0);
        check("rst_data", 64'(out_cand | out_query), 64'd0);
        check("rst_slot_leaf", 64'({out_slot, out_leaf_index, mem_addr}), 64'd0);

        // Release: in_ready rises in the first cycle and stays steady.
        wrst_n = 1'b1;
        step();
        check("release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();
        check("idle_steady", 64'({in_ready, out_valid, mem_ren, busy}), 64'b1000);

        // Leaf 5 with out_ready high.
        accept(8'd5, 55'h12_3456_789A_BCDE);
        serve(8'd5, 55'h12_3456_789A_BCDE, 1'b0, 1'b0);

        // Top leaf: addresses 2040..2047.
        accept(8'd255, 55'h7F_FFFF_0000_1111);
        serve(8'd255, 55'h7F_FFFF_0000_1111, 1'b0, 1'b0);

        // Random backpressure.
        accept(8'h3C, 55'h0A_5A5A_5A5A_5A5A);
        serve(8'h3C, 55'h0A_5A5A_5A5A_5A5A, 1'b1, 1'b0);
        out_ready = 1'b1;

        // in_valid held high during a leaf; second query waits for IDLE.
        accept(8'd17, 55'h55_0000_CAFE_F00D);
        in_valid      = 1'b1;
        in_leaf_index = 8'd9;
        serve(8'd17, 55'h55_0000_CAFE_F00D, 1'b0, 1'b1);
        p2 = in_patch;
        step();
        in_valid = 1'b0;
        serve(8'd9, p2, 1'b0, 1'b0);

        // Reset during slot 3 OUT, then a fresh query on leaf 2.
        accept(8'd7, 55'h01_2345_0000_0042);
        repeat (11) step();
        check("pre_reset_slot3", 64'({out_valid, out_slot}), 64'({1'b1, 3'd3}));
        out_ready = 1'b0;
        wrst_n    = 1'b0;
        step();
        check("mid_reset_flags", 64'({out_valid, busy, mem_ren, in_ready}), 64'd0);
        wrst_n    = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_reset_in_ready", 64'({in_ready, out_valid}), 64'b10);
        accept(8'd2, 55'h33_3333_3333_3333);
        check("leaf2_first_addr", 64'({mem_ren, mem_addr}), 64'({1'b1, 11'd16}));
        serve(8'd2, 55'h33_3333_3333_3333, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
